// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated AND/OR/NOT ALU.
package alu_pkg;

  localparam logic [1:0] CTRL_AND  = 2'b00;
  localparam logic [1:0] CTRL_OR   = 2'b01;
  localparam logic [1:0] CTRL_NOT  = 2'b10;
  localparam logic [1:0] CTRL_RSVD = 2'b11;

  // Output register occupancy: EMPTY means out_valid=0, FULL means out_valid=1.
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/andornot.sv
// Purely combinational AND / OR / NOT-a datapath; the reserved code yields zero.
module andornot
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       ctrl,
  output logic [WIDTH-1:0] s
);

  // Select the logic function; b is unused for NOT.
  always_comb begin
    s = '0;
    case (ctrl)
      CTRL_AND: s = a & b;
      CTRL_OR:  s = a | b;
      CTRL_NOT: s = ~a;
      default:  s = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end around a shared andornot datapath,
// with a single registered result slot that can drain and refill in one cycle.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_a,
  input  logic [WIDTH-1:0] in0_b,
  input  logic [1:0]       in0_ctrl,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_a,
  input  logic [WIDTH-1:0] in1_b,
  input  logic [1:0]       in1_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_id,
  output logic             out_err,
  output logic [15:0]      op_cnt
);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             id_q, id_d;
  logic             err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             can_accept;
  logic             gnt1;
  logic             accept;
  logic [WIDTH-1:0] op_a, op_b;
  logic [1:0]       op_ctrl;
  logic [WIDTH-1:0] dp_s;

  // Arbitration: a lone requester wins outright, ties go to the priority bit.
  // rst_n gates can_accept so no ready is ever shown while reset is held.
  always_comb begin
    can_accept = rst_n & ((state_q == S_EMPTY) | out_ready);
    gnt1       = in1_valid & (~in0_valid | prio_q);
    accept     = can_accept & (in0_valid | in1_valid);
    in0_ready  = accept & ~gnt1;
    in1_ready  = accept & gnt1;
  end

  // Steer the granted requester's operands into the shared datapath.
  always_comb begin
    op_a    = gnt1 ? in1_a    : in0_a;
    op_b    = gnt1 ? in1_b    : in0_b;
    op_ctrl = gnt1 ? in1_ctrl : in0_ctrl;
  end

  andornot #(.WIDTH(WIDTH)) u_dp (
    .a    (op_a),
    .b    (op_b),
    .ctrl (op_ctrl),
    .s    (dp_s)
  );

  // Next-state for the result slot, result payload, priority and counter.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    s_d     = s_q;
    id_d    = id_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_FULL;
      S_FULL:  if (out_ready && !accept) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
    if (accept) begin
      prio_d = ~gnt1;
      id_d   = gnt1;
      err_d  = (op_ctrl == CTRL_RSVD);
      s_d    = (op_ctrl == CTRL_RSVD) ? '0 : dp_s;
      cnt_d  = cnt_q + 16'd1;
    end
  end

  // State and result registers; reset discards any held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      prio_q  <= 1'b0;
      s_q     <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      s_q     <= s_d;
      id_q    <= id_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign out_s     = s_q;
  assign out_id    = id_q;
  assign out_err   = err_q;
  assign op_cnt    = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks for alu_arbiter against a behavioural model.
module tb_alu_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in0_valid, in1_valid, in0_ready, in1_ready;
  logic [W-1:0] in0_a, in0_b, in1_a, in1_b;
  logic [1:0]   in0_ctrl, in1_ctrl;
  logic         out_valid, out_ready, out_id, out_err;
  logic [W-1:0] out_s;
  logic [15:0]  op_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_a(in0_a), .in0_b(in0_b), .in0_ctrl(in0_ctrl),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_a(in1_a), .in1_b(in1_b), .in1_ctrl(in1_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_id(out_id),
    .out_err(out_err), .op_cnt(op_cnt)
  );

  function automatic logic [W-1:0] ref_op(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] c);
    case (c)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return ~a;
      default: return '0;
    endcase
  endfunction

  task automatic idle_inputs();
    in0_valid = 0; in1_valid = 0; out_ready = 1;
    in0_a = '0; in0_b = '0; in0_ctrl = 2'd0;
    in1_a = '0; in1_b = '0; in1_ctrl = 2'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    in0_valid = 1; in1_valid = 1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (out_s !== '0 || out_id !== 1'b0 || out_err !== 1'b0) begin n_bad++;
      $display("FAIL reset_out got s=%h id=%b err=%b want 0/0/0", out_s, out_id, out_err); end
    n_cmp++; if (op_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", op_cnt); end
    n_cmp++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin n_bad++;
      $display("FAIL reset_ready got %b%b want 00", in0_ready, in1_ready); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_single();
    do_reset();
    in0_valid = 1; in0_a = 8'd5; in0_b = 8'd4; in0_ctrl = 2'b00;
    #1;
    n_cmp++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin n_bad++;
      $display("FAIL single_ready got %b%b want 10", in0_ready, in1_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_s !== 8'd4 || out_id !== 1'b0 || out_err !== 1'b0) begin n_bad++;
      $display("FAIL single_out got v=%b s=%h id=%b err=%b want 1/04/0/0", out_valid, out_s, out_id, out_err); end
    n_cmp++; if (op_cnt !== 16'd1) begin n_bad++; $display("FAIL single_cnt got %0d want 1", op_cnt); end
    @(negedge clk);
    in0_valid = 0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || op_cnt !== 16'd1) begin n_bad++;
      $display("FAIL single_drain got v=%b cnt=%0d want 0/1", out_valid, op_cnt); end
  endtask

  task automatic test_alternate();
    do_reset();
    in0_valid = 1; in0_a = 8'd5; in0_b = 8'd4; in0_ctrl = 2'b01;
    in1_valid = 1; in1_a = 8'd5; in1_b = 8'd4; in1_ctrl = 2'b10;
    for (int i = 0; i < 6; i++) begin
      logic g;
      g = (i % 2) == 1;
      #1;
      n_cmp++; if (in0_ready !== !g || in1_ready !== g) begin n_bad++;
        $display("FAIL alt_ready[%0d] got %b%b want %b%b", i, in0_ready, in1_ready, !g, g); end
      @(posedge clk); #1;
      n_cmp++; if (out_id !== g || out_s !== (g ? 8'hFA : 8'h05) || op_cnt !== 16'(i + 1)) begin n_bad++;
        $display("FAIL alt_out[%0d] got id=%b s=%h cnt=%0d want %b/%h/%0d", i, out_id, out_s, op_cnt,
                 g, (g ? 8'hFA : 8'h05), i + 1); end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    in0_valid = 1; in0_a = 8'd5; in0_b = 8'd4; in0_ctrl = 2'b00;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    in0_ctrl = 2'b01;
    in1_valid = 1; in1_a = 8'd5; in1_b = 8'd0; in1_ctrl = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin n_bad++;
        $display("FAIL bp_ready[%0d] got %b%b want 00", i, in0_ready, in1_ready); end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || out_s !== 8'd4 || out_id !== 1'b0 || op_cnt !== 16'd1) begin n_bad++;
        $display("FAIL bp_hold[%0d] got v=%b s=%h id=%b cnt=%0d want 1/04/0/1", i, out_valid, out_s, out_id, op_cnt); end
      @(negedge clk);
    end
    out_ready = 1;
    #1;
    n_cmp++; if (in0_ready !== 1'b0 || in1_ready !== 1'b1) begin n_bad++;
      $display("FAIL bp_release_ready got %b%b want 01", in0_ready, in1_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_s !== 8'hFA || out_id !== 1'b1 || op_cnt !== 16'd2) begin n_bad++;
      $display("FAIL bp_release_out got s=%h id=%b cnt=%0d want FA/1/2", out_s, out_id, op_cnt); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reserved();
    do_reset();
    in1_valid = 1; in1_a = 8'd5; in1_b = 8'hF9; in1_ctrl = 2'b11;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_s !== 8'd0 || out_err !== 1'b1 || out_id !== 1'b1) begin n_bad++;
      $display("FAIL rsvd got v=%b s=%h err=%b id=%b want 1/00/1/1", out_valid, out_s, out_err, out_id); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    in1_valid = 1; in1_a = 8'd3; in1_b = 8'd1; in1_ctrl = 2'b00;
    @(posedge clk);
    @(negedge clk);
    in1_valid = 0; out_ready = 0;
    #2;
    rst_n = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || op_cnt !== 16'd0) begin n_bad++;
      $display("FAIL mid_reset got v=%b cnt=%0d want 0/0", out_valid, op_cnt); end
    @(negedge clk);
    rst_n = 1; out_ready = 1;
    in0_valid = 1; in0_a = 8'hF0; in0_b = 8'h3C; in0_ctrl = 2'b00;
    in1_valid = 1; in1_a = 8'h0F; in1_b = 8'h00; in1_ctrl = 2'b01;
    #1;
    n_cmp++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin n_bad++;
      $display("FAIL mid_first_grant got %b%b want 10", in0_ready, in1_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_id !== 1'b0 || out_s !== 8'h30) begin n_bad++;
      $display("FAIL mid_first_out got id=%b s=%h want 0/30", out_id, out_s); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random();
    logic         m_valid, m_id, m_err, m_prio;
    logic [W-1:0] m_s;
    logic [15:0]  m_cnt;
    logic         hold0, hold1, can, acc, w;
    do_reset();
    m_valid = 0; m_id = 0; m_err = 0; m_prio = 0; m_s = '0; m_cnt = 0;
    hold0 = 0; hold1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hold0) begin
        in0_valid = ($urandom_range(9) < 6); in0_a = W'($urandom); in0_b = W'($urandom);
        in0_ctrl = 2'($urandom_range(3));
      end
      if (!hold1) begin
        in1_valid = ($urandom_range(9) < 6); in1_a = W'($urandom); in1_b = W'($urandom);
        in1_ctrl = 2'($urandom_range(3));
      end
      out_ready = ($urandom_range(9) < 7);
      can = !m_valid || out_ready;
      acc = can && (in0_valid || in1_valid);
      w   = (in0_valid && in1_valid) ? m_prio : in1_valid;
      #1;
      n_cmp++; if (in0_ready !== (acc && !w) || in1_ready !== (acc && w)) begin n_bad++;
        $display("FAIL rnd_ready[%0d] got %b%b want %b%b", i, in0_ready, in1_ready, acc && !w, acc && w); end
      @(posedge clk);
      if (acc) begin
        m_valid = 1; m_id = w; m_prio = !w; m_cnt++;
        m_err = w ? (in1_ctrl == 2'd3) : (in0_ctrl == 2'd3);
        m_s   = w ? ref_op(in1_a, in1_b, in1_ctrl) : ref_op(in0_a, in0_b, in0_ctrl);
      end else if (out_ready) begin
        m_valid = 0;
      end
      hold0 = in0_valid && !(acc && !w);
      hold1 = in1_valid && !(acc && w);
      #1;
      n_cmp++; if (out_valid !== m_valid || op_cnt !== m_cnt) begin n_bad++;
        $display("FAIL rnd_state[%0d] got v=%b cnt=%0d want %b/%0d", i, out_valid, op_cnt, m_valid, m_cnt); end
      if (m_valid) begin
        n_cmp++; if (out_s !== m_s || out_id !== m_id || out_err !== m_err) begin n_bad++;
          $display("FAIL rnd_out[%0d] got s=%h id=%b err=%b want %h/%b/%b", i, out_s, out_id, out_err, m_s, m_id, m_err); end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    in0_valid = 1; in0_a = 8'd1; in0_b = 8'd1; in0_ctrl = 2'b00;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (op_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_pre got %h want FFFF", op_cnt); end
    @(posedge clk); #1;
    n_cmp++; if (op_cnt !== 16'h0000) begin n_bad++; $display("FAIL wrap_post got %h want 0000", op_cnt); end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_reserved();
    test_reset_midstream();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 WIDTH, default 8, operand/result width in bits (signed two's complement).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in0_valid / in1_valid  input  1 each  requester 0/1 presents an operation.
REQ-005 in0_ready / in1_ready  output  1 each  operation accepted this cycle when valid and ready are both high.
REQ-006 in0_a, in0_b / in1_a, in1_b  input  WIDTH each  signed operands.
REQ-007 in0_ctrl / in1_ctrl  input  2 each  op code: 00 AND, 01 OR, 10 NOT a, 11 reserved.
REQ-008 out_valid  output  1  result register holds a valid result.
REQ-009 out_ready  input  1  consumer takes the result when out_valid and out_ready are both high.
REQ-010 out_s  output  WIDTH  registered result.
REQ-011 out_id  output  1  requester that issued the result.
REQ-012 out_err  output  1  result came from reserved ctrl 11.
REQ-013 op_cnt  output  16  count of accepted operations; wraps at 16'hFFFF -> 0.

Function
REQ-014 FSM states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 can_accept = EMPTY, or FULL with out_ready=1 (drain and refill in the same cycle).
REQ-016 At most one grant per cycle, and only when can_accept=1.
REQ-017 Arbitration: only one valid requester -> grant it; both valid -> grant the requester named by the priority bit.
REQ-018 After any grant to requester i, priority bit <= 1-i (round-robin); no grant -> priority unchanged.
REQ-019 inN_ready is combinational: can_accept AND grant to N; a non-granted requester sees ready=0.
REQ-020 Result of an op accepted in cycle N is visible at out_* in cycle N+1 (latency 1).
REQ-021 Result: ctrl 00 -> a&b; 01 -> a|b; 10 -> ~a (b ignored).
REQ-022 ctrl 11 -> out_s=0 and out_err=1; a non-reserved op -> out_err=0.
REQ-023 Transitions:
- EMPTY + grant -> FULL.
- FULL + out_ready + grant -> FULL, with new data.
- FULL + out_ready + no grant -> EMPTY.
- FULL + !out_ready -> FULL, with out_s/out_id/out_err held stable.
REQ-024 op_cnt increments by 1 on each accepted op, independent of out_ready.
REQ-025 Requesters hold a/b/ctrl stable while valid=1 and ready=0; the block does not latch unaccepted inputs.

Reset
REQ-026 rst_n low asynchronously forces:
- state EMPTY, out_valid=0
- out_s=0, out_id=0, out_err=0
- priority bit=0, op_cnt=0.
REQ-027 All ready outputs read 0 while rst_n is low.
REQ-028 Reset mid-operation discards any held result; the first grant after release follows priority 0.

Structure
REQ-029 Shared package alu_pkg holds:
- ctrl encodings CTRL_AND, CTRL_OR, CTRL_NOT, CTRL_RSVD
- FSM state type.
REQ-030 The existing andornot datapath is instantiated once as the sole sub-module, fed by the granted requester's operands.
REQ-031 Reserved-op handling and the result register live in alu_arbiter.

Verification
REQ-032 Single op, out_ready=1: in0 a=5, b=4, ctrl=00 -> next cycle out_s=4, out_id=0, out_err=0; op_cnt=1.
REQ-033 Both valid every cycle, out_ready=1, in0 OR(5,4), in1 NOT(5):
- grants alternate 0,1,0,1
- results alternate 5 and 8'hFA (-6)
- each requester is granted every other cycle.
REQ-034 Backpressure: out_ready=0 for 3 cycles with a result held:
- out_s/out_id stay stable
- both ready=0
- op_cnt unchanged
- raising out_ready accepts a new op in the same cycle.
REQ-035 Reserved op: in1 a=5, b=-7, ctrl=11 -> out_s=0, out_err=1, out_id=1.
REQ-036 Reset mid-stream: assert rst_n low while FULL -> out_valid drops immediately (no clock edge) and op_cnt=0; after release with both requesters valid, in0 is granted first.
REQ-037 Wrap: preload op_cnt to 16'hFFFF through 65535 accepts, then one more accept -> op_cnt=0.
